// File: rtl/pcs_gen_pkg.sv
// Shared types and default constants for the PCS generator self-test sequencer.
package pcs_gen_pkg;

  localparam int DEF_SEL_WIDTH    = 4;
  localparam int DEF_SEL_FIRST    = 1;
  localparam int DEF_SEL_LAST     = 14;
  localparam int DEF_IDLE_SEL     = 15;
  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_DRAIN_CYCLES = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RANDOM = 3'd1,
    ST_SWEEP  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/pcs_phase_counter.sv
// Loadable down-counter shared by the random, sweep and drain phases.
// Load wins over decrement; the counter parks at zero rather than wrapping.
module pcs_phase_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pcs_gen_sequencer.sv
// Start/hold/abort controlled FSM driving the PCS generator valid, random and
// data-select controls through a random phase, a data-select sweep and a drain.
module pcs_gen_sequencer
  import pcs_gen_pkg::*;
#(
  parameter int SEL_WIDTH    = DEF_SEL_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int SEL_FIRST    = DEF_SEL_FIRST,
  parameter int SEL_LAST     = DEF_SEL_LAST,
  parameter int IDLE_SEL     = DEF_IDLE_SEL,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_hold,
  input  logic [CNT_WIDTH-1:0] i_random_len,
  input  logic [CNT_WIDTH-1:0] i_dwell_len,
  output logic                 o_valid,
  output logic                 o_random,
  output logic [SEL_WIDTH-1:0] o_data_sel,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2:0]           o_state
);

  localparam logic [SEL_WIDTH-1:0] SEL_FIRST_V = SEL_WIDTH'(SEL_FIRST);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST_V  = SEL_WIDTH'(SEL_LAST);
  localparam logic [SEL_WIDTH-1:0] IDLE_SEL_V  = SEL_WIDTH'(IDLE_SEL);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD  = CNT_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_e               state;
  logic [CNT_WIDTH-1:0] dwell_q;
  logic [CNT_WIDTH-1:0] dwell_eff;
  logic                 cnt_load;
  logic                 cnt_en;
  logic [CNT_WIDTH-1:0] cnt_load_val;
  logic                 cnt_zero;
  logic                 last_step;

  // A zero dwell would make a sweep step vanish, so it is promoted to one cycle.
  assign dwell_eff = (i_dwell_len == '0) ? CNT_ONE : i_dwell_len;
  assign last_step = (o_data_sel >= SEL_LAST_V);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = '0;
    if (!i_rst && !i_abort) begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            cnt_load     = 1'b1;
            cnt_load_val = (i_random_len != '0) ? (i_random_len - CNT_ONE)
                                                : (dwell_eff - CNT_ONE);
          end
        end
        ST_RANDOM: begin
          if (!i_hold) begin
            cnt_load     = cnt_zero;
            cnt_en       = !cnt_zero;
            cnt_load_val = dwell_q - CNT_ONE;
          end
        end
        ST_SWEEP: begin
          if (!i_hold) begin
            cnt_load     = cnt_zero;
            cnt_en       = !cnt_zero;
            cnt_load_val = last_step ? DRAIN_LOAD : (dwell_q - CNT_ONE);
          end
        end
        ST_DRAIN: cnt_en = !i_hold && !cnt_zero;
        default: ;
      endcase
    end
  end

  pcs_phase_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (i_rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      dwell_q    <= '0;
      o_valid    <= 1'b0;
      o_random   <= 1'b0;
      o_data_sel <= IDLE_SEL_V;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else if (i_abort) begin
      state      <= ST_IDLE;
      o_valid    <= 1'b0;
      o_random   <= 1'b0;
      o_data_sel <= IDLE_SEL_V;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            dwell_q <= dwell_eff;
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
            o_done  <= 1'b0;
            if (i_random_len != '0) begin
              state      <= ST_RANDOM;
              o_random   <= 1'b1;
              o_data_sel <= IDLE_SEL_V;
            end else begin
              state      <= ST_SWEEP;
              o_random   <= 1'b0;
              o_data_sel <= SEL_FIRST_V;
            end
          end
        end
        ST_RANDOM: begin
          o_valid <= !i_hold;
          if (!i_hold && cnt_zero) begin
            state      <= ST_SWEEP;
            o_random   <= 1'b0;
            o_data_sel <= SEL_FIRST_V;
          end
        end
        ST_SWEEP: begin
          if (i_hold) begin
            o_valid <= 1'b0;
          end else if (cnt_zero && last_step) begin
            state   <= ST_DRAIN;
            o_valid <= 1'b0;
          end else begin
            o_valid <= 1'b1;
            if (cnt_zero) o_data_sel <= o_data_sel + SEL_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (!i_hold && cnt_zero) begin
            state      <= ST_DONE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_data_sel <= IDLE_SEL_V;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pcs_gen_sequencer.sv
// Directed self-checking bench for pcs_gen_sequencer: reset, full passes,
// zero lengths, hold, abort, reset mid-pass and start while busy / in done.
module tb_pcs_gen_sequencer;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_abort;
  logic        i_hold;
  logic [15:0] i_random_len;
  logic [15:0] i_dwell_len;
  logic        o_valid;
  logic        o_random;
  logic [3:0]  o_data_sel;
  logic        o_busy;
  logic        o_done;
  logic [2:0]  o_state;

  int n_cmp = 0;
  int n_err = 0;

  pcs_gen_sequencer dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_hold       (i_hold),
    .i_random_len (i_random_len),
    .i_dwell_len  (i_dwell_len),
    .o_valid      (o_valid),
    .o_random     (o_random),
    .o_data_sel   (o_data_sel),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  // Outputs are packed as {valid, random, sel[3:0], busy, done, state[2:0]}.
  function automatic logic [10:0] pack(input logic v, input logic r, input int sel,
                                       input logic b, input logic d, input int st);
    logic [3:0] s4;
    logic [2:0] st3;
    s4  = 4'(sel);
    st3 = 3'(st);
    return {v, r, s4, b, d, st3};
  endfunction

  function automatic logic [10:0] observed();
    return {o_valid, o_random, o_data_sel, o_busy, o_done, o_state};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input int rl, input int dw, input logic hold);
    i_random_len = 16'(rl);
    i_dwell_len  = 16'(dw);
    i_start      = 1'b1;
    i_hold       = hold;
    step();
    i_start = 1'b0;
    i_hold  = 1'b0;
  endtask

  // Checks every cycle of a pass whose start edge has just happened. The model
  // tracks p, the number of un-held edges since start: p selects the phase and
  // select value, and a cycle right after a held edge shows valid low.
  task automatic run_pass(input string tag, input int rl, input int dw,
                          input int hold_at, input int hold_n, input int pulse_at,
                          output int edges, output int sel3_valid);
    int  dwe;
    int  sweep_end;
    int  done_pos;
    int  p;
    int  k;
    int  vcnt;
    bit  held;
    bit  hold_now;
    logic [10:0] e;
    dwe        = (dw == 0) ? 1 : dw;
    sweep_end  = rl + 14 * dwe;
    done_pos   = sweep_end + 10;
    p          = 0;
    k          = 1;
    vcnt       = 0;
    sel3_valid = 0;
    held       = 1'b0;
    while (k < 4000) begin
      if (p < rl)             e = pack(!held, 1'b1, 15, 1'b1, 1'b0, 1);
      else if (p < sweep_end) e = pack(!held, 1'b0, 1 + (p - rl) / dwe, 1'b1, 1'b0, 2);
      else if (p < done_pos)  e = pack(1'b0, 1'b0, 14, 1'b1, 1'b0, 3);
      else                    e = pack(1'b0, 1'b0, 15, 1'b0, 1'b1, 4);
      check($sformatf("%s_cyc%0d", tag, k), 32'(observed()), 32'(e));
      if (o_valid) vcnt++;
      if (o_valid && o_data_sel == 4'd3) sel3_valid++;
      if (p >= done_pos) break;
      hold_now = (k >= hold_at) && (k < hold_at + hold_n);
      i_hold   = hold_now;
      if (k == pulse_at) begin
        i_start      = 1'b1;
        i_random_len = 16'd3;
        i_dwell_len  = 16'd2;
      end
      step();
      i_hold  = 1'b0;
      i_start = 1'b0;
      held    = hold_now;
      if (!held) p++;
      k++;
    end
    edges = k - 1;
    check({tag, "_valid_total"}, 32'(vcnt), 32'(rl + 14 * dwe));
  endtask

  int edges;
  int sel3;

  initial begin
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_hold       = 1'b0;
    i_random_len = '0;
    i_dwell_len  = '0;
    #1;

    // Reset held for five cycles.
    repeat (5) step();
    check("reset", 32'(observed()), 32'(pack(1'b0, 1'b0, 15, 1'b0, 1'b0, 0)));
    i_rst = 1'b0;
    step();
    check("idle_after_reset", 32'(observed()), 32'(pack(1'b0, 1'b0, 15, 1'b0, 1'b0, 0)));

    // Full pass 100/10; a start pulse at cycle 150 (sweep) must be ignored.
    start_pass(100, 10, 1'b0);
    run_pass("passA", 100, 10, 0, 0, 150, edges, sel3);
    check("passA_edges", 32'(edges), 32'd250);
    check("passA_sel3", 32'(sel3), 32'd10);

    // Restart from DONE with zero lengths; o_done drops the cycle after start.
    start_pass(0, 0, 1'b0);
    check("restart_done_clear", 32'(o_done), 32'd0);
    run_pass("passB", 0, 0, 0, 0, 0, edges, sel3);
    check("passB_edges", 32'(edges), 32'd24);

    // Hold for five edges in the middle of the sel=3 step.
    start_pass(4, 10, 1'b0);
    run_pass("passC", 4, 10, 28, 5, 0, edges, sel3);
    check("passC_edges", 32'(edges), 32'd159);
    check("passC_sel3", 32'(sel3), 32'd10);

    // Abort while the sweep is on sel=7.
    start_pass(5, 10, 1'b0);
    repeat (69) step();
    check("pre_abort_sel7", 32'(observed()), 32'(pack(1'b1, 1'b0, 7, 1'b1, 1'b0, 2)));
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort_idle", 32'(observed()), 32'(pack(1'b0, 1'b0, 15, 1'b0, 1'b0, 0)));

    // Abort together with start keeps IDLE.
    i_abort      = 1'b1;
    i_start      = 1'b1;
    i_random_len = 16'd5;
    i_dwell_len  = 16'd2;
    step();
    i_abort = 1'b0;
    i_start = 1'b0;
    check("abort_start_idle", 32'(observed()), 32'(pack(1'b0, 1'b0, 15, 1'b0, 1'b0, 0)));

    // Fresh pass after abort, started with hold high (ignored in IDLE).
    start_pass(5, 2, 1'b1);
    run_pass("passD", 5, 2, 0, 0, 0, edges, sel3);
    check("passD_edges", 32'(edges), 32'd43);

    // Reset mid-pass behaves like abort.
    start_pass(3, 4, 1'b0);
    repeat (10) step();
    check("pre_reset_sweep", 32'(observed()), 32'(pack(1'b1, 1'b0, 2, 1'b1, 1'b0, 2)));
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("reset_midpass", 32'(observed()), 32'(pack(1'b0, 1'b0, 15, 1'b0, 1'b0, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
